pdu_lq_seq: RTL
===============

Name: pdu_lq_seq

Overview:
Parametrised successor to the PDU control path. It registers one PDU instruction together with its logical-qubit (LQ) target list and walks that list itself. Each beat it issues up to LANES LQ indices through a valid/ready output port, with a selectable scan direction. It accepts the next instruction in the same cycle as the last beat of the current one, so back-to-back instructions run without a bubble, and it holds all outputs stable under downstream backpressure.

Parameters:
NUM_LQ, 16, number of logical qubits (bits in an LQ list); must be >= 2
LQADDR_BW, $clog2(NUM_LQ), width of one LQ index
LANES, 2, maximum LQ indices issued per output beat; range 1..4, LANES <= NUM_LQ
INST_BW, 8, width of the opaque instruction payload carried alongside the list

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input buffer non-empty; instruction present
in_lqlist  in  NUM_LQ  target LQ bitmap; bit i = LQ i
in_inst  in  INST_BW  instruction payload
in_rev  in  1  scan order: 0 = ascending index, 1 = descending index
in_ready  out  1  pop strobe to the input buffer; instruction consumed when in_valid & in_ready
out_valid  out  1  beat present
out_ready  in  1  downstream accepts beat
out_lqidx  out  LANES*LQADDR_BW  lane k index at bits [k*LQADDR_BW +: LQADDR_BW]
out_lqmask  out  LANES  lane k carries a valid index
out_evenmask  out  LANES  lane k index is even (qualified by out_lqmask)
out_inst  out  INST_BW  payload of the current instruction
out_last  out  1  this beat empties the list (flush point)
zero_drop  out  1  one-cycle pulse: an instruction with an all-zero list was consumed and discarded
busy  out  1  state == RUN

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low. Reset clears state to IDLE, the lqlist, inst and rev registers to 0, and zero_drop to 0. Outputs during reset: out_valid=0, in_ready=1, all out_* fields 0, busy=0.
- States: IDLE, RUN.
- in_ready:
  - asserted when (state==IDLE), or
  - asserted when (state==RUN & out_last & out_ready).
  - Combinational from registered state and out_ready.
- Accepting an instruction (in_valid & in_ready):
  - List != 0: load lqlist, inst and rev; next state is RUN.
  - List == 0: registers are not loaded; zero_drop pulses the next cycle; next state is IDLE.
- RUN outputs:
  - out_valid = 1.
  - Lane k holds the k-th set bit of lqlist in the scan order: lowest index first when rev=0, highest first when rev=1.
  - out_lqmask is the lane-occupancy mask; unused lanes drive index 0 with mask bit 0.
  - out_evenmask[k] = out_lqmask[k] & ~out_lqidx_k[0].
  - out_last = 1 when popcount(lqlist) <= LANES.
- Beat handshake: on out_valid & out_ready, clear the issued bits from lqlist.
  - If out_last and in_valid: load the new instruction in the same edge. A list != 0 stays in RUN; a list == 0 goes to IDLE and pulses zero_drop.
  - If out_last and no in_valid: go to IDLE.
- Backpressure: while out_ready=0, lqlist, inst and rev hold, and all out_* stay stable.
- Latency: an instruction accepted in cycle N produces its first beat in N+1. Beats then issue one per cycle with out_ready held high: ceil(popcount/LANES) beats.
- Indexing: no wrap-around; indices are in 0..NUM_LQ-1. The top index (NUM_LQ-1) must issue correctly in both scan orders.
- Decoupling: in_lqlist is sampled only on acceptance; changes to it at other times have no effect.
- Reset mid-RUN: outputs drop immediately (async); the in-flight instruction is lost.

Test Plan:
- NUM_LQ=8, LANES=2, rev=0, list 8'b1010_0110, out_ready=1:
  - beat1: idx {1,2}, mask 11, even 10, last 0
  - beat2: idx {5,7}, mask 11, even 00, last 1
  - then IDLE
- Same list, rev=1:
  - beat1: {7,5}, last 0
  - beat2: {2,1}, mask 11, even 01, last 1
- Single LQ, list 8'b0001_0000: one beat, idx0=4, mask 01, even 01, last 1.
- Backpressure: hold out_ready=0 for 3 cycles during beat1 -> out_lqidx/mask/inst unchanged and in_ready=0. On release, beats resume in order.
- Back-to-back: second instruction (list 8'b0000_0001, inst 0x5A) valid during beat2 -> in_ready=1 in that cycle. Next cycle out_inst=0x5A, idx0=0, last 1, with no idle cycle.
- Zero list, then reset: zero list accepted from IDLE -> zero_drop=1 for one cycle, out_valid stays 0. Then assert rst_n=0 mid-beat on list 8'hFF -> out_valid=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/pdu_lq_seq.sv
// pdu_lq_seq: registers one PDU instruction with its logical-qubit target
// bitmap and walks that bitmap itself. Each beat issues up to LANES indices
// in ascending or descending order. The next instruction can be taken on the
// edge of the last beat, so consecutive instructions run without a bubble.
module pdu_lq_seq #(
   parameter int NUM_LQ    = 16,
   parameter int LQADDR_BW = $clog2(NUM_LQ),
   parameter int LANES     = 2,
   parameter int INST_BW   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [NUM_LQ-1:0]          in_lqlist,
   input  logic [INST_BW-1:0]         in_inst,
   input  logic                       in_rev,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*LQADDR_BW-1:0] out_lqidx,
   output logic [LANES-1:0]           out_lqmask,
   output logic [LANES-1:0]           out_evenmask,
   output logic [INST_BW-1:0]         out_inst,
   output logic                       out_last,
   output logic                       zero_drop,
   output logic                       busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                      state;
   state_t                      state_next;
   logic [NUM_LQ-1:0]           lqlist;
   logic [INST_BW-1:0]          inst;
   logic                        rev;

   logic [NUM_LQ-1:0]           remaining;
   logic [LANES*LQADDR_BW-1:0]  lane_idx;
   logic [LANES-1:0]            lane_mask;
   logic                        list_done;
   logic                        accept;
   logic                        beat_fire;
   logic                        in_nonzero;

   // Pick the first LANES set bits of the list in scan order; the bits left
   // over after picking form the list for the next beat.
   always_comb begin
      logic                 found;
      logic [LQADDR_BW-1:0] pick;
      logic [LQADDR_BW-1:0] pos;
      remaining = lqlist;
      lane_idx  = '0;
      lane_mask = '0;
      found     = 1'b0;
      pick      = '0;
      pos       = '0;
      for (int k = 0; k < LANES; k++) begin
         found = 1'b0;
         pick  = '0;
         for (int i = 0; i < NUM_LQ; i++) begin
            pos = rev ? LQADDR_BW'(NUM_LQ - 1 - i) : LQADDR_BW'(i);
            if (!found && remaining[pos]) begin
               found = 1'b1;
               pick  = pos;
            end
         end
         if (found) begin
            remaining[pick]                    = 1'b0;
            lane_idx[k*LQADDR_BW +: LQADDR_BW] = pick;
            lane_mask[k]                       = 1'b1;
         end
      end
      list_done = (remaining == '0);
   end

   // Handshake qualifiers and the gated output view of the current beat.
   always_comb begin
      busy         = (state == RUN);
      out_valid    = busy;
      out_last     = busy & list_done;
      out_lqidx    = busy ? lane_idx : '0;
      out_lqmask   = busy ? lane_mask : '0;
      out_inst     = busy ? inst : '0;
      out_evenmask = '0;
      for (int k = 0; k < LANES; k++) begin
         out_evenmask[k] = out_lqmask[k] & ~out_lqidx[k*LQADDR_BW];
      end
      in_ready   = (state == IDLE) | (busy & list_done & out_ready);
      accept     = in_valid & in_ready;
      beat_fire  = busy & out_ready;
      in_nonzero = (in_lqlist != '0);
   end

   // Next-state logic: an empty list is dropped and never enters RUN.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && in_nonzero) state_next = RUN;
         end
         RUN: begin
            if (beat_fire && list_done) begin
               state_next = (accept && in_nonzero) ? RUN : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Instruction registers: retire issued bits per beat, reload on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lqlist    <= '0;
         inst      <= '0;
         rev       <= 1'b0;
         zero_drop <= 1'b0;
      end else begin
         zero_drop <= accept & ~in_nonzero;
         if (beat_fire) lqlist <= remaining;
         if (accept && in_nonzero) begin
            lqlist <= in_lqlist;
            inst   <= in_inst;
            rev    <= in_rev;
         end
      end
   end

endmodule
